instr_loader: RTL and testbench

- Program loader for the instruction memory: the write-side counterpart of the core's instruction fetch port.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction memory write port, starting at word address 0.
- Holds the core in reset while loading and releases it only after a complete, well-formed image has been written.

---
 rtl/instr_loader.sv | 195 +++++++++++++++++++
 tb/tb_instr_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Function : Framed byte-stream program loader for the instruction memory.
//             Assembles little-endian words, writes them from address 0 and
//             holds the core in reset until a well-formed image is loaded.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_LEN_LO = 3'd2,
        S_LEN_HI = 3'd3,
        S_DATA   = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [16:0]       c_DEPTH    = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state;
    logic [15:0]       r_len, w_len;
    logic [16:0]       r_cnt, w_cnt;
    logic [1:0]        r_idx, w_idx;
    logic [23:0]       r_word, w_word;
    logic              r_in_ready, w_in_ready;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [31:0]       r_mem_wdata, w_mem_wdata;
    logic              r_cpu_rst, w_cpu_rst;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic              w_accept;
    logic [15:0]       w_len_full;

    // in_ready is a registered image of the state, so it doubles as the accept qualifier
    assign w_accept   = in_valid & r_in_ready;
    assign w_len_full = {in_data, r_len[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_len       <= w_len;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_word      <= w_word;
            r_in_ready  <= w_in_ready;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_cpu_rst   <= w_cpu_rst;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_len       = r_len;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_word      = r_word;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_cpu_rst   = r_cpu_rst;
        w_busy      = r_busy;
        w_done      = r_done;
        w_err       = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_done     = 1'b0;
                    w_err      = 1'b0;
                    w_cnt      = '0;
                    w_mem_addr = '0;
                    w_busy     = 1'b1;
                    w_cpu_rst  = 1'b1;
                    w_state    = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_accept) begin
                    w_state = (in_data == SYNC_BYTE) ? S_LEN_LO : S_ERR;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_len[7:0] = in_data;
                    w_state    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    w_len = w_len_full;
                    w_idx = '0;
                    if (w_len_full == 16'd0) begin
                        w_state = S_DONE;
                    end else if ({1'b0, w_len_full} > c_DEPTH) begin
                        w_state = S_ERR;
                    end else begin
                        w_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_idx = r_idx + 2'd1;
                    case (r_idx)
                        2'd0:    w_word[7:0]   = in_data;
                        2'd1:    w_word[15:8]  = in_data;
                        2'd2:    w_word[23:16] = in_data;
                        default: begin
                            w_mem_wdata = {in_data, r_word};
                            w_state     = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                // mem_addr wraps to 0 after a full-depth image; no write follows
                w_cnt      = r_cnt + 17'd1;
                w_mem_addr = r_mem_addr + c_ADDR_ONE;
                w_state    = (r_cnt + 17'd1 == {1'b0, r_len}) ? S_DONE : S_DATA;
            end
            S_DONE:  w_state = S_IDLE;
            S_ERR:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase

        // Status levels change on entry so they are visible during DONE/ERR
        if (w_state == S_DONE && r_state != S_DONE) begin
            w_done    = 1'b1;
            w_busy    = 1'b0;
            w_cpu_rst = 1'b0;
        end
        if (w_state == S_ERR && r_state != S_ERR) begin
            w_err     = 1'b1;
            w_busy    = 1'b0;
            w_cpu_rst = 1'b1;
        end

        w_in_ready = (w_state == S_SYNC) || (w_state == S_LEN_LO) ||
                     (w_state == S_LEN_HI) || (w_state == S_DATA);
        w_mem_we   = (w_state == S_WRITE);
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Function : Self-checking bench for instr_loader against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int         DEPTH = 256;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  frame[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;

    instr_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write capture plus per-cycle invariants
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            chk("wr_in_ready", {31'd0, in_ready}, 32'd0);
        end
        if (done === 1'b1 || err === 1'b1) begin
            chk("done_and_err", {31'd0, done & err}, 32'd0);
        end
    end

    // Reference: what a whole frame must produce, independent of timing
    task automatic model();
        int len;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (frame[0] != SYNC) begin
            exp_err = 1'b1;
            return;
        end
        len = int'(frame[1]) + 256 * int'(frame[2]);
        if (len > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(8'(i % DEPTH));
            exp_data.push_back({frame[3+4*i+3], frame[3+4*i+2], frame[3+4*i+1], frame[3+4*i]});
        end
        exp_done = 1'b1;
    endtask

    task automatic build(input int len);
        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(8'(len));
        frame.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) frame.push_back(8'($urandom));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int gap, input int start_at, output int cycles);
        int  idx;
        int  budget;
        logic acc;
        idx    = 0;
        cycles = 0;
        budget = frame.size() * 20 + 100;
        while (idx < frame.size() && cycles < budget) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) >= gap);
            in_data  = in_valid ? frame[idx] : 8'($urandom);
            start    = (idx == start_at);
            acc      = in_valid && in_ready;
            cycles++;
            @(posedge clk);
            if (acc) idx++;
        end
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        chk("send_timeout", idx, frame.size());
    endtask

    task automatic finish_check(input string tag);
        int n;
        int m;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_timeout"}, {31'd0, n < 5000}, 32'd1);
        @(negedge clk);
        chk({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
        chk({tag, "_err"},      {31'd0, err},      {31'd0, exp_err});
        chk({tag, "_cpu_rst"},  {31'd0, cpu_rst},  {31'd0, ~exp_done});
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_nwrites"},  got_addr.size(),   exp_addr.size());
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), {24'd0, got_addr[i]}, {24'd0, exp_addr[i]});
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
        chk({tag, "_mem_addr"},  {24'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,         32'd0);
        chk({tag, "_cpu_rst"},   {31'd0, cpu_rst},  32'd1);
        chk({tag, "_busy"},      {31'd0, busy},     32'd0);
        chk({tag, "_done"},      {31'd0, done},     32'd0);
        chk({tag, "_err"},       {31'd0, err},      32'd0);
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;

        // Nominal two-word image, ungapped: one bubble per word between words
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                  8'h93, 8'h80, 8'h10, 8'h00};
        model();
        do_start();
        send(0, -1, cyc);
        chk("nominal_cycles", cyc, 32'd12);
        finish_check("nominal");

        frame = '{8'h5A};
        model();
        do_start();
        send(0, -1, cyc);
        finish_check("badsync");

        frame = '{8'hA5, 8'h00, 8'h00};
        model();
        do_start();
        send(0, -1, cyc);
        finish_check("zerolen");

        frame = '{8'hA5, 8'h01, 8'h01};
        model();
        do_start();
        send(0, -1, cyc);
        finish_check("oversize");

        build(3);
        model();
        do_start();
        send(40, -1, cyc);
        finish_check("throttled");

        for (int k = 0; k < 4; k++) begin
            build($urandom_range(1, 6));
            model();
            do_start();
            send((k % 2 == 0) ? 0 : 50, -1, cyc);
            finish_check($sformatf("rand%0d", k));
        end

        // Reset after two data bytes of the first word
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        do_start();
        send(0, -1, cyc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        chk("midrst_nwrites", got_addr.size(), 32'd0);
        rst = 1'b0;
        build(2);
        model();
        do_start();
        send(20, -1, cyc);
        finish_check("after_rst");

        // Full depth with a start pulse mid-load that must be ignored
        build(DEPTH);
        model();
        do_start();
        send(10, 500, cyc);
        finish_check("fulldepth");

        do_start();
        chk("restart_done",    {31'd0, done},    32'd0);
        chk("restart_err",     {31'd0, err},     32'd0);
        chk("restart_busy",    {31'd0, busy},    32'd1);
        chk("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        build(3);
        model();
        send(0, -1, cyc);
        finish_check("reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
